// File: rtl/memory_stage.sv
// memory_stage: load/store unit between execute and write-back.
//   Non-memory instructions retire one cycle after acceptance with their
//   ALU result. Loads and stores are latched, issued to a request/grant
//   data-memory port and retired once the access completes.
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   in_valid, alu_res          instruction present, ALU result / address
//   mem_data                   right-aligned store data
//   mem_read, mem_write        load / store request (both set => store)
//   mem_size, mem_unsigned     access size (00 B, 01 H, 1x W), zero-extend
//   stall                      combinational hold request to upstream
//   dmem_req, dmem_we          memory request / write strobe
//   dmem_addr, dmem_be         word-aligned address / byte enables
//   dmem_wdata                 lane-replicated store data
//   dmem_gnt, dmem_rvalid      request accepted / read data valid
//   dmem_rdata                 read word
//   wb_valid, wb_data          retired instruction / write-back value
//   misaligned                 (MISALIGN_TRAP_EN only) misaligned-access trap
// Build option: define MISALIGN_TRAP_EN to trap misaligned half/word
// accesses instead of silently aligning them.
module memory_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] alu_res,
  input  logic [31:0] mem_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        misaligned
`endif
);

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] WAIT_GNT    = 2'd1;
  localparam logic [1:0] WAIT_RVALID = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic        we_q, we_d;
  logic        wb_valid_q, wb_valid_d;
  logic [31:0] wb_data_q, wb_data_d;
`ifdef MISALIGN_TRAP_EN
  logic        misaligned_q, misaligned_d;
`endif

  logic        mem_op_c;
  logic        trap_c;
  logic [3:0]  st_be_c;
  logic [31:0] st_wdata_c;
  logic [7:0]  ld_byte_c;
  logic [15:0] ld_half_c;
  logic [31:0] ld_ext_c;

  assign mem_op_c = mem_read | mem_write;

  // Misalignment detection; without the trap, low address bits are ignored.
`ifdef MISALIGN_TRAP_EN
  assign trap_c = ((mem_size == 2'b01) && alu_res[0]) ||
                  (mem_size[1] && (alu_res[1:0] != 2'b00));
`else
  assign trap_c = 1'b0;
`endif

  // Byte enables and lane-replicated write data for the incoming access.
  always_comb begin
    st_be_c    = 4'b1111;
    st_wdata_c = mem_data;
    if (mem_write) begin
      case (mem_size)
        2'b00: begin
          st_be_c    = 4'b0001 << alu_res[1:0];
          st_wdata_c = {4{mem_data[7:0]}};
        end
        2'b01: begin
          st_be_c    = alu_res[1] ? 4'b1100 : 4'b0011;
          st_wdata_c = {2{mem_data[15:0]}};
        end
        default: begin
          st_be_c    = 4'b1111;
          st_wdata_c = mem_data;
        end
      endcase
    end
  end

  // Load lane selection by the latched address, then extension.
  always_comb begin
    case (addr_q[1:0])
      2'd1:    ld_byte_c = dmem_rdata[15:8];
      2'd2:    ld_byte_c = dmem_rdata[23:16];
      2'd3:    ld_byte_c = dmem_rdata[31:24];
      default: ld_byte_c = dmem_rdata[7:0];
    endcase
    ld_half_c = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (size_q)
      2'b00:   ld_ext_c = unsigned_q ? {24'd0, ld_byte_c}
                                     : {{24{ld_byte_c[7]}}, ld_byte_c};
      2'b01:   ld_ext_c = unsigned_q ? {16'd0, ld_half_c}
                                     : {{16{ld_half_c[15]}}, ld_half_c};
      default: ld_ext_c = dmem_rdata;
    endcase
  end

  // Next-state, latch and handshake logic.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    we_d       = we_q;
    wb_valid_d = 1'b0;
    wb_data_d  = wb_data_q;
`ifdef MISALIGN_TRAP_EN
    misaligned_d = 1'b0;
`endif
    stall      = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (mem_op_c && !trap_c) begin
            stall      = 1'b1;
            addr_d     = alu_res;
            be_d       = st_be_c;
            wdata_d    = st_wdata_c;
            size_d     = mem_size;
            unsigned_d = mem_unsigned;
            we_d       = mem_write;
            state_d    = WAIT_GNT;
          end else begin
            // Plain ALU result, or the faulting address on a trap.
            wb_valid_d = 1'b1;
            wb_data_d  = alu_res;
`ifdef MISALIGN_TRAP_EN
            misaligned_d = mem_op_c;
`endif
          end
        end
      end
      WAIT_GNT: begin
        dmem_req = 1'b1;
        dmem_we  = we_q;
        stall    = 1'b1;
        if (dmem_gnt) begin
          if (we_q) begin
            stall      = 1'b0;
            wb_valid_d = 1'b1;
            wb_data_d  = 32'd0;
            state_d    = IDLE;
          end else begin
            state_d = WAIT_RVALID;
          end
        end
      end
      WAIT_RVALID: begin
        stall = 1'b1;
        if (dmem_rvalid) begin
          stall      = 1'b0;
          wb_valid_d = 1'b1;
          wb_data_d  = ld_ext_c;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= 32'd0;
      be_q       <= 4'd0;
      wdata_q    <= 32'd0;
      size_q     <= 2'd0;
      unsigned_q <= 1'b0;
      we_q       <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= 32'd0;
`ifdef MISALIGN_TRAP_EN
      misaligned_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      we_q       <= we_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
`ifdef MISALIGN_TRAP_EN
      misaligned_q <= misaligned_d;
`endif
    end
  end

  assign dmem_addr  = {addr_q[31:2], 2'b00};
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;
  assign wb_valid   = wb_valid_q;
  assign wb_data    = wb_data_q;
`ifdef MISALIGN_TRAP_EN
  assign misaligned = misaligned_q;
`endif

endmodule

// File: tb/tb_memory_stage.sv
// Testbench for memory_stage: directed scenarios plus a short random mix,
// with retired results checked against an expected-value queue.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] alu_res;
  logic [31:0] mem_data;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [31:0] wb_data;
`ifdef MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  int checks   = 0;
  int failures = 0;

  // Expected retirements: {misaligned, wb_data}.
  logic [32:0] exp_q[$];
  logic [32:0] mon_e;

  memory_stage dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .alu_res      (alu_res),
    .mem_data     (mem_data),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_size     (mem_size),
    .mem_unsigned (mem_unsigned),
    .stall        (stall),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_be      (dmem_be),
    .dmem_wdata   (dmem_wdata),
    .dmem_gnt     (dmem_gnt),
    .dmem_rvalid  (dmem_rvalid),
    .dmem_rdata   (dmem_rdata),
    .wb_valid     (wb_valid),
    .wb_data      (wb_data)
`ifdef MISALIGN_TRAP_EN
    ,
    .misaligned   (misaligned)
`endif
  );

  always #5 clk = ~clk;

  // Scoreboard: every retirement must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst && wb_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL wb_unexpected got=%h expected=none", wb_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (wb_data !== mon_e[31:0]) begin
          failures++;
          $display("FAIL wb_data got=%h expected=%h", wb_data, mon_e[31:0]);
        end
`ifdef MISALIGN_TRAP_EN
        if (misaligned !== mon_e[32]) begin
          failures++;
          $display("FAIL wb_misaligned got=%b expected=%b", misaligned, mon_e[32]);
        end
`endif
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid = 1'b0; alu_res = 32'd0; mem_data = 32'd0;
    mem_read = 1'b0; mem_write = 1'b0; mem_size = 2'd0; mem_unsigned = 1'b0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
  endtask

  task automatic drain(input string name);
    repeat (2) cyc();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain pending=%0d expected=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Reference models written lane-by-lane.
  function automatic logic [3:0] m_be(input logic wr, input logic [1:0] sz,
                                      input logic [31:0] a);
    logic [3:0] be;
    for (int k = 0; k < 4; k++) begin
      if (!wr || sz[1])      be[k] = 1'b1;
      else if (sz == 2'b00)  be[k] = (k == int'(a[1:0]));
      else                   be[k] = ((k / 2) == int'(a[1]));
    end
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) begin
      if (sz == 2'b00)      w[8*k +: 8] = d[7:0];
      else if (sz == 2'b01) w[8*k +: 8] = d[8*(k%2) +: 8];
      else                  w[8*k +: 8] = d[8*k +: 8];
    end
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns,
                                         input logic [31:0] a, input logic [31:0] r);
    logic [31:0] v;
    int bits;
    if (sz[1]) return r;
    if (sz == 2'b00) begin
      v = (r >> (8 * int'(a[1:0]))) & 32'h0000_00FF; bits = 8;
    end else begin
      v = (r >> (16 * int'(a[1]))) & 32'h0000_FFFF; bits = 16;
    end
    if (!uns && v[bits-1]) v = v | ~((32'd1 << bits) - 32'd1);
    return v;
  endfunction

  // One load/store with controllable grant/rvalid timing.
  task automatic do_mem(input string name, input logic rd, input logic wr,
                        input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] data,
                        input int gnt_dly, input int rv_dly, input logic rv_with_gnt,
                        input logic [31:0] rdata, input logic [3:0] ebe,
                        input logic [31:0] ewd, input logic [31:0] ewb, input int estall);
    int stalls = 0;
    in_valid = 1'b1; mem_read = rd; mem_write = wr; mem_size = sz;
    mem_unsigned = uns; alu_res = addr; mem_data = data;
    exp_q.push_back({1'b0, ewb});
    @(negedge clk);
    if (stall) stalls++;
    checks++;
    if (stall !== 1'b1 || dmem_req !== 1'b0) begin
      failures++;
      $display("FAIL %s_accept stall=%b req=%b expected stall=1 req=0", name, stall, dmem_req);
    end
    cyc();
    for (int i = 0; i <= gnt_dly; i++) begin
      dmem_gnt = (i == gnt_dly);
      if (i == gnt_dly && rv_with_gnt) begin
        dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
      end
      @(negedge clk);
      if (stall) stalls++;
      if (i == 0) begin
        checks++;
        if (dmem_req !== 1'b1 || dmem_we !== wr || dmem_addr !== {addr[31:2], 2'b00} ||
            dmem_be !== ebe || (wr && dmem_wdata !== ewd)) begin
          failures++;
          $display("FAIL %s_request req=%b we=%b addr=%h be=%b wdata=%h expected 1 %b %h %b %h",
                   name, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
                   wr, {addr[31:2], 2'b00}, ebe, ewd);
        end
      end
      cyc();
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    end
    if (!wr) begin
      for (int j = 0; j <= rv_dly; j++) begin
        dmem_rvalid = (j == rv_dly);
        dmem_rdata  = (j == rv_dly) ? rdata : 32'h5A5A_5A5A;
        @(negedge clk);
        if (stall) stalls++;
        if (j == 0) begin
          checks++;
          if (dmem_req !== 1'b0) begin
            failures++;
            $display("FAIL %s_rvalid_req got=%b expected=0", name, dmem_req);
          end
        end
        cyc();
        dmem_rvalid = 1'b0;
      end
    end
    in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    checks++;
    if (stalls != estall) begin
      failures++;
      $display("FAIL %s_stall_cycles got=%0d expected=%0d", name, stalls, estall);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    in_valid = 1'b1; alu_res = 32'h0000_0777;
    repeat (2) @(negedge clk);
    checks++;
    if (wb_valid !== 1'b0 || wb_data !== 32'd0 || stall !== 1'b0 || dmem_req !== 1'b0 ||
        dmem_we !== 1'b0 || dmem_addr !== 32'd0 || dmem_be !== 4'd0 || dmem_wdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_state wbv=%b wbd=%h stall=%b req=%b we=%b addr=%h be=%b wd=%h expected all 0",
               wb_valid, wb_data, stall, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata);
    end
    clear_inputs();
    cyc();
    rst = 1'b1;
    drain("reset");
  endtask

  task automatic test_alu();
    in_valid = 1'b1; alu_res = 32'h0000_1234;
    exp_q.push_back({1'b0, 32'h0000_1234});
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || dmem_req !== 1'b0) begin
      failures++;
      $display("FAIL alu_stall stall=%b req=%b expected 0 0", stall, dmem_req);
    end
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || wb_valid !== 1'b1) begin
      failures++;
      $display("FAIL alu_retire stall=%b wbv=%b expected 0 1", stall, wb_valid);
    end
    drain("alu");
  endtask

  task automatic test_idle_invalid();
    in_valid = 1'b0; mem_write = 1'b1; alu_res = 32'h0000_0040;
    cyc();
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b0 || stall !== 1'b0 || dmem_req !== 1'b0) begin
      failures++;
      $display("FAIL idle_invalid wbv=%b stall=%b req=%b expected 0 0 0", wb_valid, stall, dmem_req);
    end
    mem_write = 1'b0;
    drain("idle_invalid");
  endtask

  task automatic test_stores();
    do_mem("sb", 1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0103, 32'h0000_00AB, 2, 0, 1'b0,
           32'd0, 4'b1000, 32'hABAB_ABAB, 32'd0, 3);
    do_mem("sh", 1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0206, 32'h1234_BEEF, 0, 0, 1'b0,
           32'd0, 4'b1100, 32'hBEEF_BEEF, 32'd0, 1);
    do_mem("sw_rw", 1'b1, 1'b1, 2'b11, 1'b0, 32'h0000_0300, 32'hCAFE_F00D, 1, 0, 1'b0,
           32'd0, 4'b1111, 32'hCAFE_F00D, 32'd0, 2);
    drain("stores");
  endtask

  task automatic test_loads();
    do_mem("lh", 1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'd0, 0, 1, 1'b0,
           32'h8001_FFFF, 4'b1111, 32'd0, 32'hFFFF_8001, 3);
    do_mem("lbu", 1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0101, 32'd0, 0, 0, 1'b1,
           32'h0000_F300, 4'b1111, 32'd0, 32'h0000_00F3, 2);
    do_mem("lb", 1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0403, 32'd0, 1, 2, 1'b0,
           32'h9000_0000, 4'b1111, 32'd0, 32'hFFFF_FF90, 5);
    do_mem("lhu", 1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0500, 32'd0, 0, 0, 1'b0,
           32'h1111_8002, 4'b1111, 32'd0, 32'h0000_8002, 2);
    drain("loads");
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; mem_read = 1'b1; mem_size = 2'b10; alu_res = 32'h0000_0600;
    cyc();
    dmem_gnt = 1'b1;
    cyc();
    dmem_gnt = 1'b0;
    cyc();
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || dmem_req !== 1'b0 || wb_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_hold stall=%b req=%b wbv=%b expected 0 0 0", stall, dmem_req, wb_valid);
    end
    cyc();
    rst = 1'b1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h7777_7777;
    cyc();
    dmem_rvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (wb_valid !== 1'b0 || dmem_req !== 1'b0 || stall !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid_late_rvalid wbv=%b req=%b stall=%b expected 0 0 0",
                 wb_valid, dmem_req, stall);
      end
      cyc();
    end
    drain("reset_mid");
  endtask

  task automatic test_misalign();
`ifdef MISALIGN_TRAP_EN
    in_valid = 1'b1; mem_read = 1'b1; mem_size = 2'b10; alu_res = 32'h0000_0102;
    exp_q.push_back({1'b1, 32'h0000_0102});
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || dmem_req !== 1'b0) begin
      failures++;
      $display("FAIL misalign_noreq stall=%b req=%b expected 0 0", stall, dmem_req);
    end
    cyc();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (dmem_req !== 1'b0 || wb_valid !== 1'b1) begin
      failures++;
      $display("FAIL misalign_retire req=%b wbv=%b expected 0 1", dmem_req, wb_valid);
    end
`else
    do_mem("lw_unaligned", 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'd0, 0, 0, 1'b0,
           32'h8765_4321, 4'b1111, 32'd0, 32'h8765_4321, 2);
`endif
    drain("misalign");
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, d, r;
    logic [1:0]  sz;
    logic        wr, uns;
    // Two ALU ops in consecutive cycles, then a store straight after.
    in_valid = 1'b1; alu_res = 32'h0000_00A1;
    exp_q.push_back({1'b0, 32'h0000_00A1});
    cyc();
    alu_res = 32'h0000_00A2;
    exp_q.push_back({1'b0, 32'h0000_00A2});
    cyc();
    do_mem("b2b_sw", 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0700, 32'h0102_0304, 0, 0, 1'b0,
           32'd0, 4'b1111, 32'h0102_0304, 32'd0, 1);
    for (int n = 0; n < 8; n++) begin
      wr  = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 3));
      uns = 1'($urandom_range(0, 1));
      a   = $urandom;
      if (sz == 2'b01) a[0] = 1'b0;
      if (sz[1]) a[1:0] = 2'b00;
      d = $urandom;
      r = $urandom;
      do_mem("rand", !wr, wr, sz, uns, a, d, n % 3, n % 2, 1'b0, r,
             m_be(wr, sz, a), m_wdata(sz, d), wr ? 32'd0 : m_load(sz, uns, a, r),
             wr ? 1 + (n % 3) : 2 + (n % 3) + (n % 2));
    end
    drain("back_to_back");
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    test_reset();
    test_alu();
    test_idle_invalid();
    test_stores();
    test_loads();
    test_reset_mid();
    test_misalign();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
